mem_main_arbiter: RTL and testbench

Parametrised arbiter that shares the single stack/main-memory port among `NUM_REQ` RT cores plus the memory controller's result-readout path. It replaces the fixed per-lane wiring and MC override at the top level. It adds round-robin fairness, MC priority, request/done handshakes and one-outstanding-transaction tracking. It sits between the RT cores / memory controller and `mem_main`.

---
 rtl/mem_main_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_main_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_main_arbiter.sv
// Round-robin arbiter sharing the main-memory port among NUM_REQ RT cores and the MC readout path.
// Optional watchdog: define ARB_TIMEOUT_EN to force completion after TIMEOUT wait cycles.
module mem_main_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mc_re,
  input  logic [ADDR_W-1:0]          mc_addr,
  output logic                       mc_rdy,
  output logic [DATA_W-1:0]          mc_data,
  input  logic [NUM_REQ-1:0]         rq_re,
  input  logic [NUM_REQ-1:0]         rq_we,
  input  logic [NUM_REQ-1:0]         rq_mode,
  input  logic [NUM_REQ*ADDR_W-1:0]  rq_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  rq_wdata,
  output logic [NUM_REQ-1:0]         rq_done,
  output logic [DATA_W-1:0]          rq_rdata,
  output logic                       mem_re,
  output logic                       mem_we,
  output logic                       mem_mode,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_rdy,
  output logic                       busy,
  output logic                       err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic [PW-1:0]       r_ptr, r_owner;
  logic                r_own_mc, r_mask;
  logic                r_mc_rdy, r_busy, r_mem_re, r_mem_we, r_mem_mode;
  logic [NUM_REQ-1:0]  r_done;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_resp;

  logic [NUM_REQ-1:0]  w_req;
  logic                w_mc, w_hit, w_fin, w_tmo;
  logic [PW-1:0]       w_sel, w_ptr_nxt;
  logic [DATA_W-1:0]   w_fin_data;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  assign w_tmo = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT - 1));
  assign err   = r_err;
`else
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  function automatic logic [PW-1:0] wrap(input int v);
    return (v >= NUM_REQ) ? PW'(v - NUM_REQ) : PW'(v);
  endfunction

  // The last owner's request lingers for one IDLE cycle after RESP; hide it there.
  always_comb begin
    w_req = rq_re | rq_we;
    if (r_mask && !r_own_mc) w_req[r_owner] = 1'b0;
    w_mc  = mc_re && !(r_mask && r_own_mc);
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req[wrap(int'(r_ptr) + i)]) begin
        w_hit = 1'b1;
        w_sel = wrap(int'(r_ptr) + i);
      end
    end
    w_ptr_nxt  = wrap(int'(r_owner) + 1);
    w_fin      = (((r_state == S_ISSUE) || (r_state == S_WAIT)) && mem_rdy) || w_tmo;
    w_fin_data = mem_rdy ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_own_mc   <= 1'b0;
      r_mask     <= 1'b0;
      r_mc_rdy   <= 1'b0;
      r_done     <= '0;
      r_busy     <= 1'b0;
      r_mem_re   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_mode <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_resp     <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_mask   <= 1'b0;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      r_mc_rdy <= 1'b0;
      r_done   <= '0;
`ifdef ARB_TIMEOUT_EN
      if (r_state == S_IDLE)      r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_tmo && !mem_rdy)      r_err <= 1'b1;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_mc) begin
            r_own_mc   <= 1'b1;
            r_mem_re   <= 1'b1;
            r_mem_mode <= 1'b1;
            r_addr     <= mc_addr;
            r_wdata    <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end else if (w_hit) begin
            r_own_mc   <= 1'b0;
            r_owner    <= w_sel;
            r_mem_we   <= rq_we[w_sel];
            r_mem_re   <= !rq_we[w_sel];
            r_mem_mode <= rq_mode[w_sel];
            r_addr     <= rq_addr[w_sel*ADDR_W +: ADDR_W];
            r_wdata    <= rq_wdata[w_sel*DATA_W +: DATA_W];
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (w_fin) begin
            r_resp  <= w_fin_data;
            r_state <= S_RESP;
            if (r_own_mc) r_mc_rdy        <= 1'b1;
            else          r_done[r_owner] <= 1'b1;
          end else if (r_state == S_ISSUE) begin
            r_state <= S_WAIT;
          end
        end
        S_RESP: begin
          if (!r_own_mc) r_ptr <= w_ptr_nxt;
          r_mask  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mc_rdy    = r_mc_rdy;
  assign mc_data   = r_resp;
  assign rq_done   = r_done;
  assign rq_rdata  = r_resp;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_mode  = r_mem_mode;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_main_arbiter.sv
// Scoreboard bench for mem_main_arbiter: directed transactions, queued expectations, decoupled monitor.
module tb_mem_main_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mc_re;
  logic [AW-1:0]   mc_addr;
  logic            mc_rdy;
  logic [DW-1:0]   mc_data;
  logic [N-1:0]    rq_re, rq_we, rq_mode;
  logic [N*AW-1:0] rq_addr;
  logic [N*DW-1:0] rq_wdata;
  logic [N-1:0]    rq_done;
  logic [DW-1:0]   rq_rdata;
  logic            mem_re, mem_we, mem_mode;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            mem_rdy;
  logic            busy, err;

  mem_main_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .mc_re(mc_re), .mc_addr(mc_addr), .mc_rdy(mc_rdy), .mc_data(mc_data),
    .rq_re(rq_re), .rq_we(rq_we), .rq_mode(rq_mode), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .rq_done(rq_done), .rq_rdata(rq_rdata), .mem_re(mem_re), .mem_we(mem_we), .mem_mode(mem_mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [AW-1:0] addr; logic mode; logic [DW-1:0] wd; bit cwd; } iss_t;
  typedef struct { logic mc; logic [N-1:0] done; logic [DW-1:0] data; int cyc; } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  iss_t ie;
  rsp_t re_;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int mem_lat = 1;
  bit no_rsp = 1'b0, fixed_en = 1'b0;
  logic [DW-1:0] fixed_d = {16{8'hA5}};

  task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic bad(input string nm);
    n_chk++;
    $display("FAIL %s: got an output event, want none", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input bit mc, input int k, input logic [AW-1:0] a, input logic mode,
                            input logic we, input logic [DW-1:0] wd, input bit cwd,
                            input logic [DW-1:0] data, input int ecyc);
    iss_t i;
    rsp_t r;
    logic [N-1:0] one;
    one = N'(1);
    i.we = we; i.addr = a; i.mode = mode; i.wd = wd; i.cwd = cwd;
    iss_q.push_back(i);
    r.mc = mc; r.done = mc ? '0 : (one << k); r.data = data; r.cyc = ecyc;
    rsp_q.push_back(r);
  endtask

  task automatic rq_read(input int k, input logic [AW-1:0] a, input int ecyc);
    rq_addr[k*AW +: AW] = a;
    expect_txn(1'b0, k, a, 1'b0, 1'b0, rq_wdata[k*DW +: DW], 1'b1, {4{a}}, ecyc);
    rq_re[k] = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    step();
    while ((iss_q.size() != 0 || rsp_q.size() != 0 || busy) && n < max) begin
      step();
      n++;
    end
    chk("wait_bound", 129'(n < max), 129'(1));
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: rdy L cycles after the strobe cycle (L=0 means same cycle), data = replicated address.
  initial begin
    mem_rdy   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if ((mem_re || mem_we) && !no_rsp) begin
        logic [DW-1:0] d;
        d = fixed_en ? fixed_d : {4{mem_addr}};
        repeat (mem_lat) @(negedge clk);
        mem_rdy   = 1'b1;
        mem_rdata = d;
        @(negedge clk);
        mem_rdy = 1'b0;
      end
    end
  end

  // Requesters keep their request for one cycle after seeing done, then drop it.
  initial forever begin
    @(negedge clk);
    if (mc_rdy || (rq_done != '0)) begin
      logic m;
      logic [N-1:0] d;
      m = mc_rdy;
      d = rq_done;
      repeat (2) @(posedge clk);
      #1;
      if (m) mc_re = 1'b0;
      rq_re = rq_re & ~d;
      rq_we = rq_we & ~d;
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (mem_re || mem_we) begin
      if (iss_q.size() == 0) bad("unexpected_issue");
      else begin
        ie = iss_q.pop_front();
        chk("issue_op", 129'({mem_we, mem_re}), 129'({ie.we, ~ie.we}));
        chk("issue_addr", 129'(mem_addr), 129'(ie.addr));
        chk("issue_mode", 129'(mem_mode), 129'(ie.mode));
        if (ie.cwd) chk("issue_wdata", 129'(mem_wdata), 129'(ie.wd));
      end
    end
    if (mc_rdy || (rq_done != '0)) begin
      if (rsp_q.size() == 0) bad("unexpected_done");
      else begin
        re_ = rsp_q.pop_front();
        chk("done_vec", 129'({mc_rdy, rq_done}), 129'({re_.mc, re_.done}));
        chk("done_data", 129'(re_.mc ? mc_data : rq_rdata), 129'(re_.data));
        if (re_.cyc >= 0) chk("done_cycle", 129'(cyc), 129'(re_.cyc));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1);
  end

  initial begin
    int c0;
    rst_n = 1'b0; mc_re = 1'b0; mc_addr = '0;
    rq_re = '0; rq_we = '0; rq_mode = '0; rq_addr = '0; rq_wdata = '0;
    repeat (3) step();
    chk("rst_busy", 129'(busy), 129'(0));
    chk("rst_strobes", 129'({mem_re, mem_we, mem_mode}), 129'(0));
    chk("rst_addr", 129'(mem_addr), 129'(0));
    chk("rst_done", 129'({mc_rdy, rq_done}), 129'(0));
    chk("rst_err", 129'(err), 129'(0));
    rst_n = 1'b1;
    step();

    // single read, requester 2, L=3
    mem_lat = 3; fixed_en = 1'b1;
    c0 = cyc;
    rq_addr[2*AW +: AW] = 32'h8000_0010;
    expect_txn(1'b0, 2, 32'h8000_0010, 1'b0, 1'b0, '0, 1'b1, fixed_d, c0 + 5);
    rq_re[2] = 1'b1;
    wait_idle(40);
    fixed_en = 1'b0;

    // pointer now at 3: requester 3 wins over 0
    mem_lat = 1;
    step();
    rq_read(3, 32'h0000_0030, -1);
    rq_read(0, 32'h0000_000C, -1);
    wait_idle(40);

    // round robin from reset
    do_reset();
    c0 = cyc;
    rq_read(0, 32'h0000_1000, c0 + 3);
    rq_read(1, 32'h0000_1010, -1);
    rq_read(2, 32'h0000_1020, -1);
    rq_read(3, 32'h0000_1030, -1);
    wait_idle(80);

    // MC priority over requester 0
    step();
    c0 = cyc;
    mc_addr = 32'h0000_0100;
    expect_txn(1'b1, 0, 32'h0000_0100, 1'b1, 1'b0, '0, 1'b0, {4{32'h0000_0100}}, c0 + 3);
    rq_read(0, 32'h0000_0200, -1);
    mc_re = 1'b1;
    wait_idle(40);

    // both strobes on requester 1, L=0
    mem_lat = 0;
    step();
    c0 = cyc;
    rq_addr[1*AW +: AW]  = 32'h0000_0044;
    rq_wdata[1*DW +: DW] = 128'h1234;
    rq_mode[1] = 1'b1;
    expect_txn(1'b0, 1, 32'h0000_0044, 1'b1, 1'b1, 128'h1234, 1'b1, {4{32'h0000_0044}}, c0 + 2);
    rq_re[1] = 1'b1;
    rq_we[1] = 1'b1;
    wait_idle(40);
    rq_mode = '0;

    // reset during WAIT; the late mem_rdy must not produce a done
    mem_lat = 6;
    step();
    rq_addr[3*AW +: AW] = 32'h0000_0077;
    ie.we = 1'b0; ie.addr = 32'h0000_0077; ie.mode = 1'b0; ie.wd = '0; ie.cwd = 1'b1;
    iss_q.push_back(ie);
    rq_re[3] = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    rq_re[3] = 1'b0;
    step();
    chk("midrst_busy", 129'(busy), 129'(0));
    chk("midrst_done", 129'({mc_rdy, rq_done}), 129'(0));
    chk("midrst_addr", 129'(mem_addr), 129'(0));
    rst_n = 1'b1;
    repeat (6) step();
    mem_lat = 1;
    rq_read(1, 32'h0000_0011, -1);
    rq_read(2, 32'h0000_0022, -1);
    wait_idle(40);

`ifdef ARB_TIMEOUT_EN
    no_rsp = 1'b1;
    step();
    c0 = cyc;
    rq_addr[0 +: AW] = 32'h0000_0055;
    expect_txn(1'b0, 0, 32'h0000_0055, 1'b0, 1'b0, '0, 1'b1, '0, c0 + 10);
    rq_re[0] = 1'b1;
    wait_idle(40);
    chk("err_set", 129'(err), 129'(1));
    no_rsp = 1'b0;
    step();
    rq_read(1, 32'h0000_0066, -1);
    wait_idle(40);
    chk("err_sticky", 129'(err), 129'(1));
`endif

    chk("left_issue", 129'(iss_q.size()), 129'(0));
    chk("left_done", 129'(rsp_q.size()), 129'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
